// File: rtl/data_memory_pkg.sv
// Shared types and default widths for the SIC-4 data memory.
package data_memory_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

endpackage

// File: rtl/data_memory_array.sv
// Plain 1RW synchronous RAM, registered read data, no reset on contents.
module data_memory_array #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256,
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Write port plus read-before-write registered read of the same address.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_memory_sync.sv
// Data memory with valid/ready request port, registered read response,
// optional post-reset clear sweep and out-of-range address flagging.
module data_memory_sync
  import data_memory_pkg::*;
#(
  parameter int                    DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int                    ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int                    DEPTH          = 2**ADDR_WIDTH,
  parameter int                    CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int                    AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable and never matches.
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam state_e                RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
  logic                  ready_q, ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rd_oor_q, rd_oor_d;
  logic [DATA_WIDTH-1:0] rsp_hold_q, rsp_hold_d;

  logic                  accept, oor, clearing;
  logic                  mem_we;
  logic [AW-1:0]         mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata, mem_rdata;

  assign clearing = (state_q == ST_CLEAR);
  assign accept   = req_valid & ready_q;
  assign oor      = ({1'b0, req_addr} >= DEPTH_W);

  // RAM port steering: the sweep owns the port while clearing; out-of-range
  // writes are dropped. Upper address bits beyond AW only matter to the range check.
  always_comb begin
    mem_we    = ~reset & (clearing | (accept & req_write & ~oor));
    mem_addr  = clearing ? clr_ptr_q[AW-1:0] : req_addr[AW-1:0];
    mem_wdata = clearing ? CLEAR_VALUE : req_wdata;
  end

  data_memory_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  // Fresh RAM data only in a read response cycle, zero for out-of-range,
  // otherwise the held value of the previous response.
  always_comb begin
    if (rsp_valid_q) rsp_data = rd_oor_q ? '0 : mem_rdata;
    else             rsp_data = rsp_hold_q;
  end

  // Next-state: sweep pointer stops at the last word, ready tracks next state.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (clearing) begin
      if (clr_ptr_q == LAST_ADDR) state_d   = ST_IDLE;
      else                        clr_ptr_d = clr_ptr_q + 1'b1;
    end
    ready_d     = (state_d == ST_IDLE);
    rsp_valid_d = accept & ~req_write;
    rsp_err_d   = accept & oor;
    rd_oor_d    = oor;
    rsp_hold_d  = rsp_data;
  end

  // State and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RST_STATE;
      clr_ptr_q   <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rd_oor_q    <= 1'b0;
      rsp_hold_q  <= '0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rd_oor_q    <= rd_oor_d;
      rsp_hold_q  <= rsp_hold_d;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = clearing;

endmodule

// File: tb/tb_data_memory_sync.sv
// Bench for data_memory_sync: three configurations (defaults with 0xA5 fill,
// DEPTH=200, 16-bit/no-clear), vector table, corner sequences, random vs model.
module tb_data_memory_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- instance A: defaults, CLEAR_VALUE=0xA5
  logic       a_rst = 1'b1, a_vld = 1'b0, a_wr = 1'b0;
  logic [7:0] a_addr = '0, a_wd = '0;
  logic       a_rdy, a_rv, a_re, a_busy;
  logic [7:0] a_rd;

  data_memory_sync #(.CLEAR_VALUE(8'hA5)) dut_a (
    .clk(clk), .reset(a_rst), .req_valid(a_vld), .req_ready(a_rdy),
    .req_write(a_wr), .req_addr(a_addr), .req_wdata(a_wd),
    .rsp_valid(a_rv), .rsp_data(a_rd), .rsp_err(a_re), .busy(a_busy));

  // ---------------- instance B: DEPTH=200, CLEAR_VALUE=0
  logic       b_rst = 1'b1, b_vld = 1'b0, b_wr = 1'b0;
  logic [7:0] b_addr = '0, b_wd = '0;
  logic       b_rdy, b_rv, b_re, b_busy;
  logic [7:0] b_rd;

  data_memory_sync #(.DEPTH(200)) dut_b (
    .clk(clk), .reset(b_rst), .req_valid(b_vld), .req_ready(b_rdy),
    .req_write(b_wr), .req_addr(b_addr), .req_wdata(b_wd),
    .rsp_valid(b_rv), .rsp_data(b_rd), .rsp_err(b_re), .busy(b_busy));

  // ---------------- instance C: 16-bit data, 16 words, no sweep
  logic        c_rst = 1'b1, c_vld = 1'b0, c_wr = 1'b0;
  logic [3:0]  c_addr = '0;
  logic [15:0] c_wd = '0;
  logic        c_rdy, c_rv, c_re, c_busy;
  logic [15:0] c_rd;

  data_memory_sync #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .CLEAR_ON_RESET(0)) dut_c (
    .clk(clk), .reset(c_rst), .req_valid(c_vld), .req_ready(c_rdy),
    .req_write(c_wr), .req_addr(c_addr), .req_wdata(c_wd),
    .rsp_valid(c_rv), .rsp_data(c_rd), .rsp_err(c_re), .busy(c_busy));

  typedef struct packed {
    logic       vld;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wd;
    logic       exp_rv;
    logic       exp_re;
    logic [7:0] exp_d;
  } vec_t;

  vec_t tbl_a[$];
  vec_t tbl_b[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int sel, input vec_t v, input string tag);
    logic rv, re;
    logic [7:0] d;
    if (sel == 0) begin a_vld = v.vld; a_wr = v.wr; a_addr = v.addr; a_wd = v.wd; end
    else          begin b_vld = v.vld; b_wr = v.wr; b_addr = v.addr; b_wd = v.wd; end
    step();
    if (sel == 0) begin rv = a_rv; re = a_re; d = a_rd; end
    else          begin rv = b_rv; re = b_re; d = b_rd; end
    check({tag, "_rv"},   32'(rv), 32'(v.exp_rv));
    check({tag, "_err"},  32'(re), 32'(v.exp_re));
    check({tag, "_data"}, 32'(d),  32'(v.exp_d));
  endtask

  // count edges after reset release until req_ready reads 1 (edge 1 = first low-reset edge)
  task automatic wait_ready(input int sel, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (((sel == 0) ? a_rdy : b_rdy) == 1'b0 && n < 1000);
  endtask

  logic [7:0] ref_mem [200];
  logic [7:0] last_d;

  initial begin
    int n, bad;

    // A: 0x00/0x7F/0xFF after sweep, write/read-after-write, hold, ignored invalid write
    tbl_a.push_back({1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'hA5});
    tbl_a.push_back({1'b1, 1'b0, 8'h7F, 8'h00, 1'b1, 1'b0, 8'hA5});
    tbl_a.push_back({1'b1, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0, 8'hA5});
    tbl_a.push_back({1'b1, 1'b1, 8'h55, 8'hDE, 1'b0, 1'b0, 8'hA5});
    tbl_a.push_back({1'b1, 1'b0, 8'h55, 8'h00, 1'b1, 1'b0, 8'hDE});
    tbl_a.push_back({1'b1, 1'b1, 8'h02, 8'h00, 1'b0, 1'b0, 8'hDE});
    tbl_a.push_back({1'b1, 1'b0, 8'h02, 8'h00, 1'b1, 1'b0, 8'h00});
    tbl_a.push_back({1'b1, 1'b1, 8'h02, 8'h1F, 1'b0, 1'b0, 8'h00});
    tbl_a.push_back({1'b1, 1'b0, 8'h02, 8'h00, 1'b1, 1'b0, 8'h1F});
    tbl_a.push_back({1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h1F});
    tbl_a.push_back({1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h1F});
    tbl_a.push_back({1'b0, 1'b1, 8'h03, 8'h77, 1'b0, 1'b0, 8'h1F});
    tbl_a.push_back({1'b1, 1'b0, 8'h03, 8'h00, 1'b1, 1'b0, 8'hA5});
    // B: out-of-range write/read at the DEPTH boundary and just below it
    tbl_b.push_back({1'b1, 1'b1, 8'hC8, 8'h33, 1'b0, 1'b1, 8'h00});
    tbl_b.push_back({1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00});
    tbl_b.push_back({1'b1, 1'b1, 8'h00, 8'h5A, 1'b0, 1'b0, 8'h00});
    tbl_b.push_back({1'b1, 1'b0, 8'hC8, 8'h00, 1'b1, 1'b1, 8'h00});
    tbl_b.push_back({1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h5A});
    tbl_b.push_back({1'b1, 1'b1, 8'hC7, 8'h77, 1'b0, 1'b0, 8'h5A});
    tbl_b.push_back({1'b1, 1'b0, 8'hC7, 8'h00, 1'b1, 1'b0, 8'h77});
    tbl_b.push_back({1'b1, 1'b1, 8'hFF, 8'h12, 1'b0, 1'b1, 8'h77});
    tbl_b.push_back({1'b1, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b1, 8'h00});
    tbl_b.push_back({1'b1, 1'b0, 8'hC7, 8'h00, 1'b1, 1'b0, 8'h77});

    // ---------------- A: reset cycle and sweep length
    step();
    check("a_rst_ready", 32'(a_rdy), 32'd0);
    check("a_rst_busy",  32'(a_busy), 32'd1);
    check("a_rst_rv",    32'(a_rv), 32'd0);
    check("a_rst_err",   32'(a_re), 32'd0);
    check("a_rst_data",  32'(a_rd), 32'd0);
    a_rst = 1'b0;
    wait_ready(0, n);
    check("a_sweep_len", 32'(n), 32'd256);
    check("a_busy_done", 32'(a_busy), 32'd0);

    foreach (tbl_a[i]) run_vec(0, tbl_a[i], $sformatf("a_vec%0d", i));
    a_vld = 1'b0;

    // ---------------- A: reset at sweep cycle 100, requests while busy
    a_rst = 1'b1; step(); a_rst = 1'b0;
    repeat (100) step();
    check("a_mid_busy_pre", 32'(a_busy), 32'd1);
    a_rst = 1'b1; step(); a_rst = 1'b0;
    check("a_mid_busy_rst", 32'(a_busy), 32'd1);
    check("a_mid_ready",    32'(a_rdy), 32'd0);
    n = 0; bad = 0;
    while (!a_rdy && n < 1000) begin
      if (n == 20) begin a_vld = 1'b1; a_wr = 1'b1; a_addr = 8'h00; a_wd = 8'h3C; end
      if (n == 40) begin a_wr = 1'b0; a_addr = 8'h10; end
      step();
      n++;
      if (a_rv || a_re) bad++;
    end
    a_vld = 1'b0;
    check("a_resweep_len", 32'(n), 32'd256);
    check("a_busy_rsp",    32'(bad), 32'd0);
    run_vec(0, {1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'hA5}, "a_busy_nowrite");
    run_vec(0, {1'b1, 1'b0, 8'h55, 8'h00, 1'b1, 1'b0, 8'hA5}, "a_resweep_fill");
    a_vld = 1'b0;

    // ---------------- B: DEPTH=200 sweep and boundary table
    b_rst = 1'b1; step(); b_rst = 1'b0;
    wait_ready(1, n);
    check("b_sweep_len", 32'(n), 32'd200);
    foreach (tbl_b[i]) run_vec(1, tbl_b[i], $sformatf("b_vec%0d", i));
    b_vld = 1'b0;

    // ---------------- B: random traffic against an array model
    b_rst = 1'b1; step(); b_rst = 1'b0;
    wait_ready(1, n);
    foreach (ref_mem[i]) ref_mem[i] = 8'h00;
    last_d = 8'h00;
    for (int k = 0; k < 400; k++) begin
      logic vld, wr, exp_rv, exp_re;
      logic [7:0] addr, wd;
      vld  = ($urandom_range(0, 3) != 0);
      wr   = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(190, 209));
      wd   = 8'($urandom);
      b_vld = vld; b_wr = wr; b_addr = addr; b_wd = wd;
      step();
      exp_rv = vld && !wr;
      exp_re = vld && (int'(addr) >= 200);
      if (exp_rv) last_d = (int'(addr) < 200) ? ref_mem[addr] : 8'h00;
      if (vld && wr && int'(addr) < 200) ref_mem[addr] = wd;
      check($sformatf("b_rnd%0d_rv", k),   32'(b_rv), 32'(exp_rv));
      check($sformatf("b_rnd%0d_err", k),  32'(b_re), 32'(exp_re));
      check($sformatf("b_rnd%0d_data", k), 32'(b_rd), 32'(last_d));
    end
    b_vld = 1'b0;

    // ---------------- C: no sweep, 16-bit data
    step();
    check("c_rst_ready", 32'(c_rdy), 32'd0);
    check("c_rst_busy",  32'(c_busy), 32'd0);
    check("c_rst_rv",    32'(c_rv), 32'd0);
    c_rst = 1'b0;
    step();
    check("c_ready_1cyc", 32'(c_rdy), 32'd1);
    c_vld = 1'b1; c_wr = 1'b1; c_addr = 4'hF; c_wd = 16'hBEEF;
    step();
    check("c_wr_rv", 32'(c_rv), 32'd0);
    c_wr = 1'b0;
    step();
    check("c_rd_rv",   32'(c_rv), 32'd1);
    check("c_rd_data", 32'(c_rd), 32'hBEEF);
    check("c_rd_err",  32'(c_re), 32'd0);
    c_rst = 1'b1;
    step();
    check("c_rstrd_rv",    32'(c_rv), 32'd0);
    check("c_rstrd_data",  32'(c_rd), 32'd0);
    check("c_rstrd_ready", 32'(c_rdy), 32'd0);
    c_rst = 1'b0; c_vld = 1'b0;
    step();
    check("c_ready_again", 32'(c_rdy), 32'd1);
    c_vld = 1'b1;
    step();
    c_vld = 1'b0;
    check("c_keep_rv",   32'(c_rv), 32'd1);
    check("c_keep_data", 32'(c_rd), 32'hBEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory_sync.md
# data_memory_sync

Parametrised single-port data memory for the SIC-4 datapath, replacing the fixed 8-bit × 256 data memory. It uses a valid/ready request port and a registered read response. An optional post-reset clear sweep initialises every word. Addresses beyond a non-power-of-two depth are detected and flagged. It sits between the execute/memory stage and the load/store writeback path.

## Interface
Parameters:
- DATA_WIDTH, 8, bits per word
- ADDR_WIDTH, 8, address bus width
- DEPTH, 2**ADDR_WIDTH, number of implemented words, 1..2**ADDR_WIDTH
- CLEAR_ON_RESET, 1, 1 = sweep CLEAR_VALUE into every word after reset
- CLEAR_VALUE, 0, DATA_WIDTH-bit fill value

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  word address
- req_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  one-cycle pulse, read data valid
- rsp_data  out  DATA_WIDTH  read data, held between responses
- rsp_err  out  1  pulses with rsp_valid on an out-of-range read; also pulses alone on an out-of-range write
- busy  out  1  clear sweep in progress

## Operation
- Accept = req_valid & req_ready, sampled at a rising edge.
- States: CLEAR and IDLE.
- Reset: the state goes to CLEAR if CLEAR_ON_RESET=1, otherwise to IDLE.
  - clr_ptr=0, rsp_valid=0, rsp_err=0, rsp_data=0.
  - Memory contents are not reset except by the sweep.
- CLEAR:
  - busy=1, req_ready=0. Requests are ignored, not queued.
  - Each cycle: mem[clr_ptr] <= CLEAR_VALUE, then clr_ptr++.
  - When clr_ptr==DEPTH-1, the write happens and the state goes to IDLE on the same edge.
- IDLE:
  - busy=0, req_ready=1 every cycle. There is no internal backpressure.
- Accepted write:
  - If req_addr < DEPTH, mem[req_addr] <= req_wdata.
  - If req_addr >= DEPTH, no write occurs, and rsp_err pulses in the next cycle with rsp_valid=0.
- Accepted read:
  - In the next cycle rsp_valid=1 and rsp_data = mem[req_addr].
  - If req_addr >= DEPTH, rsp_data=0 and rsp_err=1.
- Single port: one access per cycle, so no read/write collision is possible.
  - A read accepted the cycle after a write to the same address returns the new data.
- rsp_data keeps its last value when rsp_valid=0. Only read responses update it.
- Reset asserted mid-sweep or mid-access: everything above applies again.
  - The sweep restarts at 0.
  - A pending read response is dropped (rsp_valid=0 in the cycle after reset).
- clr_ptr is ADDR_WIDTH bits wide. It never wraps, because the sweep stops at DEPTH-1.
- The out-of-range comparison is unsigned against DEPTH. With DEPTH=2**ADDR_WIDTH it is never true.

## Timing
- Read latency: 1 cycle, from the accept edge to the rsp_valid edge.
- Write: takes effect at the accept edge and is visible to a read accepted on the next edge.
- Throughput: 1 request per cycle in IDLE.
- The sweep takes exactly DEPTH cycles.
  - CLEAR_ON_RESET=1: req_ready first reads 1 in the DEPTH-th cycle after reset deasserts, counting the first low-reset edge as edge 1.
  - CLEAR_ON_RESET=0: req_ready=1 one cycle after reset deasserts.
- During the reset cycle itself: req_ready=0, busy=CLEAR_ON_RESET, rsp_valid=0, rsp_err=0.
- All outputs are registered or decoded from the state register. There is no combinational path from the request inputs to any output.

## Structure
- Package data_memory_pkg:
  - state enum {ST_CLEAR, ST_IDLE}
  - default width constants DATA_WIDTH_DEF=8, ADDR_WIDTH_DEF=8
- Sub-module data_memory_array:
  - Plain 1RW synchronous RAM with parameters DATA_WIDTH and DEPTH.
  - Ports: clk, we, addr, wdata, rdata (registered).
- The top level holds the FSM, clear pointer, address mux (clr_ptr vs req_addr), range check, and response registers.

## Test plan
- Defaults, CLEAR_ON_RESET=1, CLEAR_VALUE=0xA5: release reset and count cycles until req_ready=1 → exactly 256 cycles. Then read 0x00, 0x7F and 0xFF → each rsp_data=0xA5.
- Write 0x55←0xDE, then read 0x55 on the next cycle → rsp_valid one cycle after the read accept, rsp_data=0xDE, rsp_err=0.
- Read 0x02 (holds 0x00) → 0x00. Write 0x02←0x1F back-to-back with a read of 0x02 → 0x1F. Then idle 3 cycles → rsp_data stays 0x1F, rsp_valid=0.
- DEPTH=200: write 0xC8←0x33 → rsp_err pulses with rsp_valid=0. Read 0xC8 → rsp_valid=1, rsp_err=1, rsp_data=0x00. Read 0x00 afterwards → value unaffected.
- Assert reset at sweep cycle 100 for one cycle → busy stays 1 and the sweep restarts. req_ready=1 appears 256 cycles after the second reset release. Requests driven while busy → no write, no response.
- CLEAR_ON_RESET=0, DATA_WIDTH=16, ADDR_WIDTH=4: req_ready=1 one cycle after reset. Write 0xF←0xBEEF, read it → 0xBEEF. Read with reset asserted in the response cycle → rsp_valid=0.
